branch_predictor_bht: RTL and testbench

//  Dynamic branch predictor for the 5-stage RV32 pipeline. Predicts conditional branches
//  in IF using a direct-mapped BTB with 2-bit saturating counters.

---
 rtl/branch_predictor_bht_pkg.sv | 22 ++
 rtl/branch_predictor_bht_sat_counter2.sv | 19 +
 rtl/branch_predictor_bht.sv | 107 ++++++++++
 tb/tb_branch_predictor_bht.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_bht_pkg.sv
// Shared definitions for the IF/ID branch predictor: table geometry, counter encodings
// and PC increment.
package branch_predictor_bht_pkg;

    localparam int unsigned BP_ENTRIES = 64;
    localparam int unsigned BP_INDEX_W = 6;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Word-aligned PCs: two low bits dropped, INDEX_W bits of index, remainder is tag.
    function automatic int unsigned bp_tag_w(input int unsigned index_w);
        return 32 - index_w - 2;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter2.sv
// Two-bit saturating counter next-state function used on the training path.
module bp_sat_counter2
    import branch_predictor_bht_pkg::*;
(
    input  logic [1:0] i_cur,
    input  logic       i_taken,
    output logic [1:0] o_next
);

    always_comb begin
        o_next = i_cur;
        if (i_taken) begin
            if (i_cur != CTR_ST) o_next = i_cur + 2'd1;
        end else begin
            if (i_cur != CTR_SNT) o_next = i_cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BTB with 2-bit counters: predicts in IF, trains and flags mispredicts
// from the ID-stage comparator, and keeps branch/mispredict statistics.
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int unsigned ENTRIES = BP_ENTRIES,
    parameter int unsigned INDEX_W = BP_INDEX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        id_valid,
    input  logic        id_is_branch,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_target,
    input  logic        id_pred_taken,
    input  logic        cmp_result,
    input  logic        stall,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int unsigned TAG_W = bp_tag_w(INDEX_W);

    logic             r_valid [ENTRIES];
    logic [TAG_W-1:0] r_tag   [ENTRIES];
    logic [31:0]      r_tgt   [ENTRIES];
    logic [1:0]       r_ctr   [ENTRIES];
    logic [31:0]      r_branch_cnt;
    logic [31:0]      r_mispred_cnt;

    logic [INDEX_W-1:0] w_if_idx;
    logic [TAG_W-1:0]   w_if_tag;
    logic               w_if_hit;
    logic [INDEX_W-1:0] w_id_idx;
    logic [TAG_W-1:0]   w_id_tag;
    logic               w_id_hit;
    logic               w_upd;
    logic               w_mispredict;
    logic [1:0]         w_ctr_next;
    logic               w_unused_if_lsbs;

    assign w_unused_if_lsbs = ^if_pc[1:0];

    // IF lookup reads the registered table only, so a same-cycle write is not visible.
    assign w_if_idx    = if_pc[INDEX_W+1:2];
    assign w_if_tag    = if_pc[31:INDEX_W+2];
    assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken  = w_if_hit & r_ctr[w_if_idx][1];
    assign pred_target = w_if_hit ? r_tgt[w_if_idx] : '0;

    assign w_id_idx     = id_pc[INDEX_W+1:2];
    assign w_id_tag     = id_pc[31:INDEX_W+2];
    assign w_id_hit     = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);
    assign w_upd        = id_valid & id_is_branch & ~stall;
    assign w_mispredict = w_upd & (cmp_result != id_pred_taken);
    assign mispredict   = w_mispredict;
    assign redirect_pc  = cmp_result ? id_target : id_pc + PC_INC;

    bp_sat_counter2 u_ctr (
        .i_cur   (r_ctr[w_id_idx]),
        .i_taken (cmp_result),
        .o_next  (w_ctr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_tgt[i]   <= '0;
                r_ctr[i]   <= CTR_WNT;
            end
        end else if (w_upd) begin
            if (cmp_result) begin
                if (w_id_hit) begin
                    r_ctr[w_id_idx] <= w_ctr_next;
                end else begin
                    r_valid[w_id_idx] <= 1'b1;
                    r_tag[w_id_idx]   <= w_id_tag;
                    r_ctr[w_id_idx]   <= CTR_WT;
                end
                r_tgt[w_id_idx] <= id_target;
            end else if (w_id_hit) begin
                r_ctr[w_id_idx] <= w_ctr_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_upd) begin
            if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_mispredict && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: directed vector table, then randomized traffic checked
// against an array-based reference model, then an asynchronous mid-run reset.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_valid, id_is_branch, id_pred_taken, cmp_result, stall;
    logic [31:0] id_pc, id_target;
    logic        mispredict;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    branch_predictor_bht #(.ENTRIES(64), .INDEX_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .id_valid      (id_valid),
        .id_is_branch  (id_is_branch),
        .id_pc         (id_pc),
        .id_target     (id_target),
        .id_pred_taken (id_pred_taken),
        .cmp_result    (cmp_result),
        .stall         (stall),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: one record per table slot, plain integer counters.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    int unsigned m_bc, m_mc;

    function automatic int unsigned slot_of(input logic [31:0] pc);
        return (pc / 4) % 64;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / 256;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[slot_of(pc)] : 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic m_commit();
        int unsigned s;
        bit h;
        s = slot_of(id_pc);
        h = m_hit(id_pc);
        if (id_valid && id_is_branch && !stall) begin
            if (m_bc != 32'hFFFF_FFFF) m_bc++;
            if ((cmp_result != id_pred_taken) && (m_mc != 32'hFFFF_FFFF)) m_mc++;
            if (cmp_result) begin
                if (h) begin
                    if (m_ctr[s] < 3) m_ctr[s]++;
                end else begin
                    m_valid[s] = 1'b1;
                    m_tag[s]   = tag_of(id_pc);
                    m_ctr[s]   = 2;
                end
                m_tgt[s] = id_target;
            end else if (h && m_ctr[s] > 0) begin
                m_ctr[s]--;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] if_pc;
        logic        idv, isbr;
        logic [31:0] id_pc, id_tgt;
        logic        idpt, cmp, stl;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mp;
        logic [31:0] e_rd, e_bc, e_mc;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic [31:0] ipc, input logic v, input logic b,
                                input logic [31:0] ipd, input logic [31:0] it,
                                input logic pt, input logic c, input logic st,
                                input logic ept, input logic [31:0] eptgt, input logic emp,
                                input logic [31:0] erd, input logic [31:0] ebc,
                                input logic [31:0] emc);
        vec_t r;
        r.if_pc = ipc; r.idv = v; r.isbr = b; r.id_pc = ipd; r.id_tgt = it;
        r.idpt = pt; r.cmp = c; r.stl = st; r.e_pt = ept; r.e_ptgt = eptgt;
        r.e_mp = emp; r.e_rd = erd; r.e_bc = ebc; r.e_mc = emc;
        return r;
    endfunction

    task automatic drive(input logic [31:0] ipc, input logic v, input logic b,
                         input logic [31:0] ipd, input logic [31:0] it,
                         input logic pt, input logic c, input logic st);
        if_pc = ipc; id_valid = v; id_is_branch = b; id_pc = ipd;
        id_target = it; id_pred_taken = pt; cmp_result = c; stall = st;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        m_commit();
        #1;
    endtask

    task automatic check_vs_model(input string tagname);
        chk({tagname, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, m_pred(if_pc)});
        chk({tagname, ".pred_target"}, pred_target, m_ptgt(if_pc));
        chk({tagname, ".mispredict"},  {31'd0, mispredict},
            {31'd0, id_valid & id_is_branch & ~stall & (cmp_result != id_pred_taken)});
        chk({tagname, ".redirect_pc"}, redirect_pc, cmp_result ? id_target : id_pc + 32'd4);
        chk({tagname, ".branch_cnt"},  branch_cnt, m_bc);
        chk({tagname, ".mispred_cnt"}, mispred_cnt, m_mc);
    endtask

    task automatic random_cycles(input int n);
        logic [31:0] ipc, ipd;
        logic pt;
        for (int k = 0; k < n; k++) begin
            ipc = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
            ipd = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
            if (($urandom % 2) == 0) pt = m_pred(ipd);
            else pt = 1'($urandom);
            drive(ipc, ($urandom % 4) != 0, ($urandom % 4) != 0, ipd,
                  $urandom, pt, 1'($urandom), ($urandom % 6) == 0);
            @(negedge clk);
            check_vs_model("rnd");
            finish_cycle();
        end
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0;
        drive(32'h100, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        #12;
        chk("reset.pred_taken",  {31'd0, pred_taken}, 32'd0);
        chk("reset.pred_target", pred_target, 32'd0);
        chk("reset.branch_cnt",  branch_cnt, 32'd0);
        chk("reset.mispred_cnt", mispred_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vecs[0]  = mk(32'h100, 0, 0, 32'h000, 32'h000, 0, 0, 0, 0, 32'h000, 0, 32'h004, 0, 0);
        vecs[1]  = mk(32'h100, 1, 1, 32'h100, 32'h140, 0, 1, 0, 0, 32'h000, 1, 32'h140, 0, 0);
        vecs[2]  = mk(32'h100, 0, 0, 32'h100, 32'h140, 0, 0, 0, 1, 32'h140, 0, 32'h104, 1, 1);
        vecs[3]  = mk(32'h100, 1, 1, 32'h100, 32'h140, 1, 1, 0, 1, 32'h140, 0, 32'h140, 1, 1);
        vecs[4]  = mk(32'h100, 1, 1, 32'h100, 32'h140, 1, 1, 0, 1, 32'h140, 0, 32'h140, 2, 1);
        vecs[5]  = mk(32'h100, 1, 1, 32'h100, 32'h140, 1, 1, 0, 1, 32'h140, 0, 32'h140, 3, 1);
        vecs[6]  = mk(32'h100, 1, 1, 32'h100, 32'h140, 1, 0, 0, 1, 32'h140, 1, 32'h104, 4, 1);
        vecs[7]  = mk(32'h100, 1, 1, 32'h100, 32'h140, 1, 0, 0, 1, 32'h140, 1, 32'h104, 5, 2);
        vecs[8]  = mk(32'h100, 0, 0, 32'h100, 32'h140, 0, 0, 0, 0, 32'h140, 0, 32'h104, 6, 3);
        vecs[9]  = mk(32'h100, 1, 1, 32'h200, 32'h260, 0, 1, 0, 0, 32'h140, 1, 32'h260, 6, 3);
        vecs[10] = mk(32'h100, 0, 0, 32'h200, 32'h260, 0, 0, 0, 0, 32'h000, 0, 32'h204, 7, 4);
        vecs[11] = mk(32'h200, 0, 0, 32'h200, 32'h260, 0, 0, 0, 1, 32'h260, 0, 32'h204, 7, 4);
        vecs[12] = mk(32'h200, 1, 1, 32'h200, 32'h260, 1, 0, 1, 1, 32'h260, 0, 32'h204, 7, 4);
        vecs[13] = mk(32'h200, 0, 0, 32'h200, 32'h260, 0, 0, 0, 1, 32'h260, 0, 32'h204, 7, 4);
        vecs[14] = mk(32'h200, 1, 1, 32'hFFFF_FFFC, 32'h0, 1, 0, 0, 1, 32'h260, 1, 32'h000, 7, 4);
        vecs[15] = mk(32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 32'h000, 0, 32'h000, 8, 5);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].if_pc, vecs[i].idv, vecs[i].isbr, vecs[i].id_pc,
                  vecs[i].id_tgt, vecs[i].idpt, vecs[i].cmp, vecs[i].stl);
            @(negedge clk);
            chk($sformatf("vec%0d.pred_taken", i),  {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
            chk($sformatf("vec%0d.pred_target", i), pred_target, vecs[i].e_ptgt);
            chk($sformatf("vec%0d.mispredict", i),  {31'd0, mispredict}, {31'd0, vecs[i].e_mp});
            chk($sformatf("vec%0d.redirect_pc", i), redirect_pc, vecs[i].e_rd);
            chk($sformatf("vec%0d.branch_cnt", i),  branch_cnt, vecs[i].e_bc);
            chk($sformatf("vec%0d.mispred_cnt", i), mispred_cnt, vecs[i].e_mc);
            finish_cycle();
        end

        random_cycles(300);

        // Allocate a known entry, confirm it predicts, then reset between clock edges.
        drive(32'h0, 1, 1, 32'h300, 32'h3A0, 0, 1, 0);
        finish_cycle();
        drive(32'h300, 0, 0, 32'h300, 32'h3A0, 0, 0, 0);
        #1;
        chk("prereset.pred_taken",  {31'd0, pred_taken}, 32'd1);
        chk("prereset.pred_target", pred_target, 32'h3A0);
        chk("prereset.branch_cnt_min", {31'd0, branch_cnt >= 32'd10}, 32'd1);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("asyncreset.pred_taken",  {31'd0, pred_taken}, 32'd0);
        chk("asyncreset.pred_target", pred_target, 32'd0);
        chk("asyncreset.branch_cnt",  branch_cnt, 32'd0);
        chk("asyncreset.mispred_cnt", mispred_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        random_cycles(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
